// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD-card SPI bus arbiter.
// States, owner encodings and the idle levels driven onto the SD pins.
package sd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT0  = 2'd1,
        GRANT1  = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    localparam logic OWNER_MCU = 1'b0;
    localparam logic OWNER_GST = 1'b1;

    localparam logic CS_IDLE   = 1'b1;
    localparam logic SCK_IDLE  = 1'b0;
    localparam logic MOSI_IDLE = 1'b1;

endpackage

// File: rtl/sd_arb_timer.sv
// Loadable counter with a terminal flag.
// Counts up or down depending on COUNT_UP, and holds at the terminal value
// instead of wrapping. The terminal value is an input: the down-counting
// instance ties it to zero.
module sd_arb_timer #(
    parameter int unsigned WIDTH    = 4,
    parameter bit          COUNT_UP = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] term_val_i,
    output logic             term_o
);

    logic [WIDTH-1:0] count_q, count_d;

    assign term_o = (count_q == term_val_i);

    // Load has priority; counting stops once the terminal value is reached.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && !term_o) begin
            count_d = COUNT_UP ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sd_spi_arbiter.sv
// Round-robin arbiter sharing one SD-card SPI bus between the control MCU
// (requester 0) and the guest core (requester 1). Ownership changes only
// through RELEASE, which holds the pins idle for IDLE_GAP cycles.
// Optional feature: define SD_ARB_TIMEOUT_EN to revoke a grant when the owner
// leaves cs/sck frozen for TIMEOUT cycles while the other side is waiting.
module sd_spi_arbiter
    import sd_arb_pkg::*;
#(
    parameter int unsigned IDLE_GAP = 8,
    parameter int unsigned TIMEOUT  = 65535
) (
    input  logic clk,
    input  logic reset_n,
    input  logic mcu_req,
    input  logic gst_req,
    output logic mcu_gnt,
    output logic gst_gnt,
    input  logic mcu_cs,
    input  logic mcu_sck,
    input  logic mcu_mosi,
    input  logic gst_cs,
    input  logic gst_sck,
    input  logic gst_mosi,
    output logic mcu_miso,
    output logic gst_miso,
    output logic sd_cs,
    output logic sd_sck,
    output logic sd_mosi,
    input  logic sd_miso,
    output logic owner,
    output logic busy,
    output logic timeout_pulse
);

    localparam int unsigned GAP_W = $clog2(IDLE_GAP + 1);

    arb_state_e state_q, state_d;
    logic [1:0] gnt_q, gnt_d;           // bit 0 = MCU, bit 1 = guest
    logic       owner_q, owner_d;
    logic       last_q, last_d;         // requester served most recently
    logic       cs_q, sck_q, mosi_q;
    logic [1:0] req_eff;
    logic       gap_term;
    logic       to_fire;

`ifdef SD_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic [1:0] blocked_q, blocked_d;   // revoked owner stays out until req drops
    logic       tp_q;
    logic       prev_cs_q, prev_sck_q;
    logic       in_grant, sel_gst, own_cs, own_sck, other_req, changed, to_term;

    assign in_grant  = (state_q == GRANT0) || (state_q == GRANT1);
    assign sel_gst   = (state_q == GRANT1);
    assign own_cs    = sel_gst ? gst_cs  : mcu_cs;
    assign own_sck   = sel_gst ? gst_sck : mcu_sck;
    assign other_req = sel_gst ? mcu_req : gst_req;
    assign changed   = (own_cs != prev_cs_q) || (own_sck != prev_sck_q);
    assign req_eff   = {gst_req, mcu_req} & ~blocked_q;

    sd_arb_timer #(.WIDTH(TO_W), .COUNT_UP(1'b1)) u_timeout (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (!in_grant || changed),
        .load_val_i ('0),
        .en_i       (in_grant && other_req && !changed),
        .term_val_i (TO_W'(TIMEOUT)),
        .term_o     (to_term)
    );

    // Block a revoked requester until it lets go of its request.
    always_comb begin
        blocked_d = blocked_q & {gst_req, mcu_req};
        if (to_fire) begin
            blocked_d[owner_q] = 1'b1;
        end
    end

    // Activity history, blocking flags and the revocation pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_cs_q  <= CS_IDLE;
            prev_sck_q <= SCK_IDLE;
            blocked_q  <= 2'b00;
            tp_q       <= 1'b0;
        end else begin
            prev_cs_q  <= own_cs;
            prev_sck_q <= own_sck;
            blocked_q  <= blocked_d;
            tp_q       <= to_fire;
        end
    end

    assign timeout_pulse = tp_q;
`else
    assign req_eff       = {gst_req, mcu_req};
    assign timeout_pulse = 1'b0;
`endif

    sd_arb_timer #(.WIDTH(GAP_W), .COUNT_UP(1'b0)) u_gap (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     ((state_d == RELEASE) && (state_q != RELEASE)),
        .load_val_i (GAP_W'(IDLE_GAP - 1)),
        .en_i       (state_q == RELEASE),
        .term_val_i ('0),
        .term_o     (gap_term)
    );

    // Next-state, round-robin choice and grant decode.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        to_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_eff[0] && (!req_eff[1] || last_q == OWNER_GST)) begin
                    state_d = GRANT0;
                    owner_d = OWNER_MCU;
                end else if (req_eff[1]) begin
                    state_d = GRANT1;
                    owner_d = OWNER_GST;
                end
            end
            GRANT0: begin
                if (!mcu_req) begin
                    state_d = RELEASE;
                    last_d  = OWNER_MCU;
                end
`ifdef SD_ARB_TIMEOUT_EN
                else if (to_term) begin
                    state_d = RELEASE;
                    last_d  = OWNER_MCU;
                    to_fire = 1'b1;
                end
`endif
            end
            GRANT1: begin
                if (!gst_req) begin
                    state_d = RELEASE;
                    last_d  = OWNER_GST;
                end
`ifdef SD_ARB_TIMEOUT_EN
                else if (to_term) begin
                    state_d = RELEASE;
                    last_d  = OWNER_GST;
                    to_fire = 1'b1;
                end
`endif
            end
            RELEASE: begin
                if (gap_term) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // The grant lags state entry by one cycle but drops with it.
        gnt_d[0] = (state_q == GRANT0) && (state_d == GRANT0);
        gnt_d[1] = (state_q == GRANT1) && (state_d == GRANT1);
    end

    // State, grant and pin registers; pins follow the granted requester only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            owner_q <= OWNER_MCU;
            last_q  <= OWNER_GST;
            cs_q    <= CS_IDLE;
            sck_q   <= SCK_IDLE;
            mosi_q  <= MOSI_IDLE;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            if (gnt_q[0]) begin
                cs_q   <= mcu_cs;
                sck_q  <= mcu_sck;
                mosi_q <= mcu_mosi;
            end else if (gnt_q[1]) begin
                cs_q   <= gst_cs;
                sck_q  <= gst_sck;
                mosi_q <= gst_mosi;
            end else begin
                cs_q   <= CS_IDLE;
                sck_q  <= SCK_IDLE;
                mosi_q <= MOSI_IDLE;
            end
        end
    end

    assign mcu_gnt  = gnt_q[0];
    assign gst_gnt  = gnt_q[1];
    assign mcu_miso = gnt_q[0] ? sd_miso : 1'b1;
    assign gst_miso = gnt_q[1] ? sd_miso : 1'b1;
    assign sd_cs    = cs_q;
    assign sd_sck   = sck_q;
    assign sd_mosi  = mosi_q;
    assign owner    = owner_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Bench for sd_spi_arbiter: grant/revocation events are queued with their
// expected cycle and checked by an independent monitor; pin, MISO and reset
// behaviour are checked directly. Build with SD_ARB_TIMEOUT_EN to exercise
// the revocation path.
module tb_sd_spi_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    logic mcu_req, gst_req, mcu_gnt, gst_gnt;
    logic mcu_cs, mcu_sck, mcu_mosi, gst_cs, gst_sck, gst_mosi;
    logic mcu_miso, gst_miso, sd_cs, sd_sck, sd_mosi, sd_miso;
    logic owner, busy, timeout_pulse;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t;
    bit mon_en = 1'b0;

    typedef struct {
        int   cyc;
        logic m;
        logic g;
        logic tp;
    } ev_t;
    ev_t exp_q[$];

    sd_spi_arbiter #(.IDLE_GAP(8), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .mcu_req(mcu_req), .gst_req(gst_req),
        .mcu_gnt(mcu_gnt), .gst_gnt(gst_gnt),
        .mcu_cs(mcu_cs), .mcu_sck(mcu_sck), .mcu_mosi(mcu_mosi),
        .gst_cs(gst_cs), .gst_sck(gst_sck), .gst_mosi(gst_mosi),
        .mcu_miso(mcu_miso), .gst_miso(gst_miso),
        .sd_cs(sd_cs), .sd_sck(sd_sck), .sd_mosi(sd_mosi), .sd_miso(sd_miso),
        .owner(owner), .busy(busy), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b expected %b (cyc %0d)", name, got, want, cyc);
        end
    endtask

    task automatic expect_ev(input int c, input logic m, input logic g, input logic tp);
        exp_q.push_back('{c, m, g, tp});
    endtask

    // Monitor: every change of {mcu_gnt, gst_gnt, timeout_pulse} must match the next queued event.
    logic [2:0] prev_out = 3'b000;
    always @(negedge clk) begin
        logic [2:0] cur;
        ev_t e;
        cur = {mcu_gnt, gst_gnt, timeout_pulse};
        if (mon_en) begin
            total++;
            if (mcu_gnt && gst_gnt) begin
                bad++;
                $display("FAIL onehot_gnt: got both grants high (cyc %0d)", cyc);
            end
            if (cur !== prev_out) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event: got gnt/gnt/tp=%b at cyc %0d, none expected", cur, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || cur !== {e.m, e.g, e.tp}) begin
                        bad++;
                        $display("FAIL event: got %b at cyc %0d expected %b at cyc %0d",
                                 cur, cyc, {e.m, e.g, e.tp}, e.cyc);
                    end else begin
                        $display("event ok: gnt/gnt/tp=%b at cyc %0d", cur, cyc);
                    end
                end
            end
        end
        prev_out = cur;
    end

    initial begin
        reset_n = 1'b0;
        mcu_req = 1'b0; gst_req = 1'b0;
        mcu_cs = 1'b1; mcu_sck = 1'b0; mcu_mosi = 1'b1;
        gst_cs = 1'b1; gst_sck = 1'b0; gst_mosi = 1'b1;
        sd_miso = 1'b1;
        step(2);
        chk("rst_sd_cs", sd_cs, 1'b1);
        chk("rst_sd_sck", sd_sck, 1'b0);
        chk("rst_sd_mosi", sd_mosi, 1'b1);
        chk("rst_mcu_gnt", mcu_gnt, 1'b0);
        chk("rst_gst_gnt", gst_gnt, 1'b0);
        chk("rst_owner", owner, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tp", timeout_pulse, 1'b0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        step(2);

        // MCU alone: grant, pin latency, MISO routing, guest inputs ignored.
        t = cyc; mcu_req = 1'b1; expect_ev(t + 2, 1'b1, 1'b0, 1'b0);
        step(2);
        gst_cs = 1'b0; gst_sck = 1'b1; gst_mosi = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mcu_cs = 1'b0; mcu_sck = i[0]; mcu_mosi = i[1]; sd_miso = ~i[0];
            #1;
            chk("a_mcu_miso", mcu_miso, ~i[0]);
            chk("a_gst_miso", gst_miso, 1'b1);
            step(1);
            chk("a_sd_cs", sd_cs, 1'b0);
            chk("a_sd_sck", sd_sck, i[0]);
            chk("a_sd_mosi", sd_mosi, i[1]);
        end
        t = cyc; mcu_req = 1'b0; expect_ev(t + 1, 1'b0, 1'b0, 1'b0);
        step(1);
        chk("a_cs_last_owner", sd_cs, 1'b0);
        chk("a_busy_release", busy, 1'b1);
        step(1);
        chk("a_cs_idle", sd_cs, 1'b1);
        chk("a_sck_idle", sd_sck, 1'b0);
        chk("a_mosi_idle", sd_mosi, 1'b1);
        step(6);
        chk("a_busy_gap_end", busy, 1'b1);
        step(1);
        chk("a_idle", busy, 1'b0);
        mcu_cs = 1'b1; mcu_sck = 1'b0; mcu_mosi = 1'b1;

        // Guest alone, drops request with cs still low.
        t = cyc; gst_req = 1'b1; gst_cs = 1'b1; gst_sck = 1'b0; gst_mosi = 1'b1;
        expect_ev(t + 2, 1'b0, 1'b1, 1'b0);
        step(2);
        chk("c_owner", owner, 1'b1);
        gst_cs = 1'b0; gst_sck = 1'b1; gst_mosi = 1'b0; sd_miso = 1'b0;
        #1;
        chk("c_gst_miso", gst_miso, 1'b0);
        chk("c_mcu_miso", mcu_miso, 1'b1);
        step(1);
        chk("c_sd_cs", sd_cs, 1'b0);
        chk("c_sd_sck", sd_sck, 1'b1);
        chk("c_sd_mosi", sd_mosi, 1'b0);
        t = cyc; gst_req = 1'b0; expect_ev(t + 1, 1'b0, 1'b0, 1'b0);
        step(1);
        chk("c_cs_hold", sd_cs, 1'b0);
        chk("c_sck_hold", sd_sck, 1'b1);
        step(1);
        chk("c_cs_forced", sd_cs, 1'b1);
        chk("c_sck_idle", sd_sck, 1'b0);
        chk("c_mosi_idle", sd_mosi, 1'b1);
        step(8);
        gst_cs = 1'b1; gst_sck = 1'b0; gst_mosi = 1'b1; sd_miso = 1'b1;

        // Asynchronous reset in the middle of an MCU transfer.
        t = cyc; mcu_req = 1'b1; expect_ev(t + 2, 1'b1, 1'b0, 1'b0);
        step(2);
        mcu_cs = 1'b0; mcu_sck = 1'b1;
        step(2);
        chk("d_cs_low", sd_cs, 1'b0);
        mon_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("d_rst_cs", sd_cs, 1'b1);
        chk("d_rst_sck", sd_sck, 1'b0);
        chk("d_rst_mosi", sd_mosi, 1'b1);
        chk("d_rst_gnt", mcu_gnt, 1'b0);
        chk("d_rst_busy", busy, 1'b0);
        chk("d_rst_owner", owner, 1'b0);
        mcu_req = 1'b0;
        step(2);
        reset_n = 1'b1; mcu_cs = 1'b1; mcu_sck = 1'b0;
        step(1);
        chk("d_idle_after", busy, 1'b0);
        mon_en = 1'b1;

        // Both request after reset: MCU first, then round-robin alternation.
        t = cyc; mcu_req = 1'b1; gst_req = 1'b1; expect_ev(t + 2, 1'b1, 1'b0, 1'b0);
        step(6);
        t = cyc; mcu_req = 1'b0;
        expect_ev(t + 1, 1'b0, 1'b0, 1'b0);
        expect_ev(t + 11, 1'b0, 1'b1, 1'b0);
        step(3);
        mcu_req = 1'b1;
        step(8);
        chk("b_owner_gst", owner, 1'b1);
        step(3);
        t = cyc; gst_req = 1'b0;
        expect_ev(t + 1, 1'b0, 1'b0, 1'b0);
        expect_ev(t + 11, 1'b1, 1'b0, 1'b0);
        step(11);
        chk("b_owner_mcu", owner, 1'b0);
        step(2);
        t = cyc; mcu_req = 1'b0; expect_ev(t + 1, 1'b0, 1'b0, 1'b0);
        step(10);

        // MCU holds a frozen bus while the guest waits.
`ifdef SD_ARB_TIMEOUT_EN
        t = cyc; mcu_req = 1'b1; mcu_cs = 1'b0; mcu_sck = 1'b0;
        expect_ev(t + 2, 1'b1, 1'b0, 1'b0);
        expect_ev(t + 19, 1'b0, 1'b0, 1'b1);
        expect_ev(t + 20, 1'b0, 1'b0, 1'b0);
        expect_ev(t + 29, 1'b0, 1'b1, 1'b0);
        step(2);
        gst_req = 1'b1;
        step(27);
        chk("e_revoked", mcu_gnt, 1'b0);
        chk("e_busy", busy, 1'b1);
        step(2);
        t = cyc; gst_req = 1'b0; mcu_req = 1'b0; expect_ev(t + 1, 1'b0, 1'b0, 1'b0);
        step(10);
        // Activity every 10 cycles keeps the grant alive.
        t = cyc; mcu_req = 1'b1; mcu_cs = 1'b0; mcu_sck = 1'b0;
        expect_ev(t + 2, 1'b1, 1'b0, 1'b0);
        step(2);
        gst_req = 1'b1;
        repeat (6) begin
            step(10);
            mcu_sck = ~mcu_sck;
        end
        chk("e_kept", mcu_gnt, 1'b1);
        chk("e_no_tp", timeout_pulse, 1'b0);
`else
        t = cyc; mcu_req = 1'b1; mcu_cs = 1'b0; mcu_sck = 1'b0;
        expect_ev(t + 2, 1'b1, 1'b0, 1'b0);
        step(2);
        gst_req = 1'b1;
        step(40);
        chk("e_kept", mcu_gnt, 1'b1);
        chk("e_no_tp", timeout_pulse, 1'b0);
`endif
        t = cyc; mcu_req = 1'b0;
        expect_ev(t + 1, 1'b0, 1'b0, 1'b0);
        expect_ev(t + 11, 1'b0, 1'b1, 1'b0);
        step(11);
        chk("e_gst_gnt", gst_gnt, 1'b1);
        step(2);
        t = cyc; gst_req = 1'b0; expect_ev(t + 1, 1'b0, 1'b0, 1'b0);
        step(10);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_events: got %0d outstanding expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
